// File: rtl/fall_event_scheduler_if.sv
// Event-reporting channel of fall_event_scheduler: valid/ready handshake carrying a channel id.
interface fall_event_scheduler_if #(
  parameter int unsigned IDW = 2
) ();
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_ready;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/fall_event_scheduler.sv
// Falling-edge detector on N status lines, one pending event per channel, round-robin drained
// through a 1-entry event slot. Optional drop counter: FALL_SCHED_DROP_CNT_EN.
module fall_event_scheduler #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N-1:0]           sig_in,
  fall_event_scheduler_if.master evt,
  output logic [N-1:0]           ovf,
`ifdef FALL_SCHED_DROP_CNT_EN
  output logic [7:0]             drop_cnt,
`endif
  output logic                   busy
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e         state_q;
  logic [N-1:0]   prev_q, pending_q, ovf_q;
  logic [IDW-1:0] id_q, rr_q;

  logic [N-1:0]   fall, load_mask, drop, pending_d;
  logic           load, found;
  logic [IDW-1:0] sel, scan_idx, rr_next;

  assign fall = en ? (prev_q & ~sig_in) : '0;
  assign load = ((state_q == StEmpty) || evt.evt_ready) && (|pending_q);

  // First pending channel at or above rr_q, wrapping.
  always_comb begin
    sel      = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      scan_idx = IDW'((int'(rr_q) + k) % int'(N));
      if (!found && pending_q[scan_idx]) begin
        sel   = scan_idx;
        found = 1'b1;
      end
    end
  end

  assign rr_next   = IDW'((int'(sel) + 1) % int'(N));
  assign load_mask = load ? (N'(1) << sel) : '0;
  // A fall on the channel being loaded re-arms it rather than dropping.
  assign drop      = fall & pending_q & ~load_mask;
  assign pending_d = (pending_q & ~load_mask) | fall;

`ifdef FALL_SCHED_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  int         drop_sum;

  always_comb begin
    drop_sum   = int'(drop_cnt_q) + $countones(drop);
    drop_cnt_d = (drop_sum > 255) ? 8'd255 : drop_sum[7:0];
  end

  assign drop_cnt = drop_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StEmpty;
      prev_q     <= '0;
      pending_q  <= '0;
      ovf_q      <= '0;
      id_q       <= '0;
      rr_q       <= '0;
`ifdef FALL_SCHED_DROP_CNT_EN
      drop_cnt_q <= '0;
`endif
    end else begin
      prev_q    <= sig_in;
      pending_q <= pending_d;
      ovf_q     <= ovf_q | drop;
`ifdef FALL_SCHED_DROP_CNT_EN
      drop_cnt_q <= drop_cnt_d;
`endif
      unique case (state_q)
        StEmpty: begin
          if (load) begin
            state_q <= StFull;
            id_q    <= sel;
            rr_q    <= rr_next;
          end
        end
        StFull: begin
          if (evt.evt_ready) begin
            if (load) begin
              id_q <= sel;
              rr_q <= rr_next;
            end else begin
              state_q <= StEmpty;
            end
          end
        end
      endcase
    end
  end

  assign evt.evt_valid = (state_q == StFull);
  assign evt.evt_id    = id_q;
  assign ovf           = ovf_q;
  assign busy          = (|pending_q) || (state_q == StFull);

endmodule

// File: tb/tb_fall_event_scheduler.sv
// Directed bench for fall_event_scheduler with an expected-id scoreboard on the event channel.
module tb_fall_event_scheduler;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic         clk;
  logic         rst;
  logic         en;
  logic [N-1:0] sig_in;
  logic [N-1:0] ovf;
  logic         busy;
`ifdef FALL_SCHED_DROP_CNT_EN
  logic [7:0]   drop_cnt;
`endif

  fall_event_scheduler_if #(.IDW(IDW)) evt_if ();

  fall_event_scheduler #(.N(N), .IDW(IDW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sig_in   (sig_in),
    .evt      (evt_if),
    .ovf      (ovf),
`ifdef FALL_SCHED_DROP_CNT_EN
    .drop_cnt (drop_cnt),
`endif
    .busy     (busy)
  );

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(evt_if.evt_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Accept happens on the next posedge; compare against the oldest expected id.
  always @(negedge clk) begin
    if (rst && evt_if.evt_valid && evt_if.evt_ready) begin
      if (exp_q.size() == 0) begin
        check("evt_expected", 32'(exp_q.size() != 0), 32'd1);
      end else begin
        check("evt_id_order", 32'(evt_if.evt_id), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst              = 1'b0;
    en               = 1'b1;
    sig_in           = '0;
    evt_if.evt_ready = 1'b0;
    cyc(2);
    rst = 1'b1;
    check_idle("reset");
    check("reset_id", 32'(evt_if.evt_id), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
`ifdef FALL_SCHED_DROP_CNT_EN
    check("reset_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

    // Single fall on ch2
    evt_if.evt_ready = 1'b1;
    sig_in = 4'hF;
    cyc(2);
    sig_in = 4'hB;
    exp_q.push_back(2);
    cyc(1);
    check("single_pend_valid", 32'(evt_if.evt_valid), 32'd0);
    check("single_pend_busy", 32'(busy), 32'd1);
    cyc(1);
    check("single_valid", 32'(evt_if.evt_valid), 32'd1);
    check("single_id", 32'(evt_if.evt_id), 32'd2);
    cyc(1);
    check_idle("single_done");
    sig_in = 4'hF;
    cyc(2);

    // Move rr_ptr to 1 via a ch0 event, then fall on 0, 1, 3 together
    sig_in = 4'hE;
    exp_q.push_back(0);
    cyc(3);
    check_idle("rr_prep");
    sig_in = 4'hF;
    cyc(2);
    sig_in = 4'b0100;
    exp_q.push_back(1);
    exp_q.push_back(3);
    exp_q.push_back(0);
    cyc(2);
    check("rr_id0", 32'(evt_if.evt_id), 32'd1);
    cyc(1);
    check("rr_id1", 32'(evt_if.evt_id), 32'd3);
    cyc(1);
    check("rr_id2", 32'(evt_if.evt_id), 32'd0);
    check("rr_valid", 32'(evt_if.evt_valid), 32'd1);
    cyc(1);
    check_idle("rr_done");
    sig_in = 4'hF;
    cyc(2);

    // Backpressure: slot holds ch0, second fall pends, third fall drops
    evt_if.evt_ready = 1'b0;
    sig_in = 4'hE;
    exp_q.push_back(0);
    cyc(1);
    sig_in = 4'hF;
    cyc(1);
    check("bp_loaded_id", 32'(evt_if.evt_id), 32'd0);
    sig_in = 4'hE;
    exp_q.push_back(0);
    cyc(1);
    check("bp_hold_id_a", 32'(evt_if.evt_id), 32'd0);
    sig_in = 4'hF;
    cyc(1);
    check("bp_ovf_before", 32'(ovf), 32'd0);
    sig_in = 4'hE;
    cyc(1);
    check("bp_ovf", 32'(ovf), 32'b0001);
    check("bp_hold_id_b", 32'(evt_if.evt_id), 32'd0);
    check("bp_hold_valid", 32'(evt_if.evt_valid), 32'd1);
`ifdef FALL_SCHED_DROP_CNT_EN
    check("bp_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    evt_if.evt_ready = 1'b1;
    cyc(2);
    check_idle("bp_done");
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    sig_in = 4'hF;
    cyc(2);

    // Same-edge reload: ch1 falls on the edge its pending bit is loaded
    evt_if.evt_ready = 1'b0;
    sig_in = 4'hD;
    exp_q.push_back(1);
    cyc(1);
    sig_in = 4'hF;
    cyc(1);
    sig_in = 4'hD;
    exp_q.push_back(1);
    cyc(1);
    sig_in = 4'hF;
    cyc(1);
    sig_in = 4'hD;
    exp_q.push_back(1);
    evt_if.evt_ready = 1'b1;
    cyc(1);
    check("same_edge_ovf", 32'(ovf), 32'b0001);
    check("same_edge_valid", 32'(evt_if.evt_valid), 32'd1);
    check("same_edge_id", 32'(evt_if.evt_id), 32'd1);
    check("same_edge_busy", 32'(busy), 32'd1);
    cyc(1);
    check("same_edge_id2", 32'(evt_if.evt_id), 32'd1);
    cyc(1);
    check_idle("same_edge_done");
    check("same_edge_queue_empty", 32'(exp_q.size()), 32'd0);
    sig_in = 4'hF;
    cyc(2);

    // Enable gating on ch3
    en = 1'b0;
    sig_in = 4'h7;
    cyc(2);
    check_idle("en_low");
    en = 1'b1;
    cyc(3);
    check_idle("en_high");
    sig_in = 4'hF;
    cyc(2);

    // Reset mid-operation: slot full with 3 more pending
    evt_if.evt_ready = 1'b0;
    sig_in = 4'h0;
    cyc(2);
    check("rst_mid_valid_before", 32'(evt_if.evt_valid), 32'd1);
    rst = 1'b0;
    #1;
    check_idle("rst_mid");
    check("rst_mid_id", 32'(evt_if.evt_id), 32'd0);
    check("rst_mid_ovf", 32'(ovf), 32'd0);
`ifdef FALL_SCHED_DROP_CNT_EN
    check("rst_mid_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    cyc(1);
    rst = 1'b1;
    evt_if.evt_ready = 1'b1;
    cyc(4);
    check_idle("rst_after");

    // Drop storm: counter sums popcounts and saturates at 255
    evt_if.evt_ready = 1'b0;
    sig_in = 4'hF;
    cyc(1);
    sig_in = 4'h0;
    cyc(2);
    sig_in = 4'hF;
    cyc(1);
    sig_in = 4'h0;
    cyc(1);
    check("storm_ovf_first", 32'(ovf), 32'b1110);
`ifdef FALL_SCHED_DROP_CNT_EN
    check("storm_drop_cnt_first", 32'(drop_cnt), 32'd3);
`endif
    for (int i = 0; i < 79; i++) begin
      sig_in = 4'hF;
      cyc(1);
      sig_in = 4'h0;
      cyc(1);
    end
    check("storm_ovf", 32'(ovf), 32'hF);
`ifdef FALL_SCHED_DROP_CNT_EN
    check("storm_drop_cnt_sat", 32'(drop_cnt), 32'd255);
`endif
    for (int i = 0; i < 5; i++) begin
      sig_in = 4'hF;
      cyc(1);
      sig_in = 4'h0;
      cyc(1);
    end
`ifdef FALL_SCHED_DROP_CNT_EN
    check("storm_drop_cnt_hold", 32'(drop_cnt), 32'd255);
`endif
    rst = 1'b0;
    #1;
    check_idle("final_rst");
    cyc(1);
    rst = 1'b1;
    cyc(2);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
